// File: rtl/mux_rr_sel.sv
// Registered N-channel valid/ready multiplexer with either an externally selected
// channel or round-robin arbitration feeding a single output register stage.
module mux_rr_sel #(
    parameter int N_CH = 4,
    parameter int WIDTH = 8,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic [CH_W-1:0]       sel,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH*WIDTH-1:0] in_data,
    output logic [N_CH-1:0]       in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [CH_W-1:0]       out_ch,
    input  logic                  out_ready
);

    logic                  out_valid_reg;
    logic [WIDTH-1:0]      out_data_reg;
    logic [CH_W-1:0]       out_ch_reg;
    logic [CH_W-1:0]       ptr_reg;

    logic                  load_en;
    logic                  sel_found;
    logic                  rr_found;
    logic [CH_W-1:0]       rr_grant;
    logic                  grant_vld;
    logic [CH_W-1:0]       grant_ch;
    logic [CH_W-1:0]       ptr_next;

    logic [WIDTH-1:0]      chan_data [N_CH];
    logic [CH_W-1:0]       cand_idx  [N_CH];
    logic [N_CH-1:0]       cand_vld;

    assign load_en = !out_valid_reg || out_ready;

    // Candidate gi is the channel gi steps after ptr, wrapped modulo N_CH so that
    // non-power-of-2 channel counts never index past the last channel.
    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_chan
            logic [CH_W:0] sum;

            assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
            assign sum           = {1'b0, ptr_reg} + (CH_W+1)'(gi);
            assign cand_idx[gi]  = (sum >= (CH_W+1)'(N_CH))
                                   ? CH_W'(sum - (CH_W+1)'(N_CH))
                                   : sum[CH_W-1:0];
            assign cand_vld[gi]  = in_valid[cand_idx[gi]];
            assign in_ready[gi]  = !rst && load_en && grant_vld
                                   && (grant_ch == CH_W'(gi));
        end
    endgenerate

    // Scanning from the far end lets the nearest valid candidate win last.
    always_comb begin
        rr_found = 1'b0;
        rr_grant = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (cand_vld[k]) begin
                rr_found = 1'b1;
                rr_grant = cand_idx[k];
            end
        end
    end

    assign sel_found = (int'(sel) < N_CH) && in_valid[sel];

    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        if (mode) begin
            grant_vld = rr_found;
            grant_ch  = rr_grant;
        end else begin
            grant_vld = sel_found;
            grant_ch  = sel;
        end
    end

    assign ptr_next = (grant_ch == CH_W'(N_CH - 1)) ? '0 : grant_ch + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_ch_reg    <= '0;
            ptr_reg       <= '0;
        end else if (load_en) begin
            if (grant_vld) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= chan_data[grant_ch];
                out_ch_reg    <= grant_ch;
                if (mode) begin
                    ptr_reg <= ptr_next;
                end
            end else begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_ch    = out_ch_reg;

endmodule
